// File: rtl/ir_pkg.sv
// Shared definitions for the IR proximity sensor logic: scan FSM states,
// per-channel status codes and default timing constants at 100 MHz.
package ir_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        UPDATE  = 2'd3
    } ir_state_t;

    // Per-channel status codes reported to the navigation logic
    localparam logic [1:0] IR_NONE = 2'b00;  // not yet measured
    localparam logic [1:0] IR_DET  = 2'b10;  // object detected
    localparam logic [1:0] IR_CLR  = 2'b01;  // path clear

    // Default timing constants
    localparam int IR_DEF_NUM_CH     = 4;
    localparam int IR_DEF_SETTLE_CYC = 1000;      // 10 us emitter warm-up
    localparam int IR_DEF_WINDOW_CYC = 30000000;  // 300 ms slot, settle included
    localparam int IR_DEF_THRESHOLD  = 300000;    // high-count below this = object
    localparam int IR_DEF_CNT_W      = 26;

endpackage

// File: rtl/ir_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
// Both stages reset to 0.
module ir_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture to resolve metastability on each bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make r_sync take the old r_meta,
            // giving two real flop stages rather than one collapsed stage.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ir_scan_sequencer.sv
// Time-multiplexed IR proximity sensor scanner. Each channel in turn gets
// its emitter enabled, a settle interval, then a measurement window in
// which synchronized high cycles are counted; the count is turned into a
// 2-bit detect/clear status per channel.
module ir_scan_sequencer
    import ir_pkg::*;
#(
    parameter int NUM_CH     = IR_DEF_NUM_CH,
    parameter int SETTLE_CYC = IR_DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = IR_DEF_WINDOW_CYC,
    parameter int THRESHOLD  = IR_DEF_THRESHOLD,
    parameter int CNT_W      = IR_DEF_CNT_W
) (
    input  logic                      CLK100MHZ,
    input  logic                      CPU_RESETN,
    input  logic                      run,
    input  logic [NUM_CH-1:0]         ir_in,
    output logic [NUM_CH-1:0]         emit_en,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic [2*NUM_CH-1:0]       iflags,
    output logic                      flags_upd,
    output logic                      scan_done,
    output logic                      busy
);

    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0] THRESH      = CNT_W'(THRESHOLD);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    ir_state_t           r_state;
    ir_state_t           w_state_nxt;
    logic [CH_W-1:0]     r_ch_sel;
    logic [CH_W-1:0]     w_ch_sel_nxt;
    logic [CNT_W-1:0]    r_slot_cnt;
    logic [CNT_W-1:0]    w_slot_nxt;
    logic [CNT_W-1:0]    r_high_cnt;
    logic [CNT_W-1:0]    w_high_nxt;
    logic [2*NUM_CH-1:0] r_iflags;
    logic [2*NUM_CH-1:0] w_iflags_nxt;
    logic [NUM_CH-1:0]   r_emit_en;
    logic [NUM_CH-1:0]   w_emit_nxt;
    logic                r_flags_upd;
    logic                w_flags_upd_nxt;
    logic                r_scan_done;
    logic                w_scan_done_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic [NUM_CH-1:0]   w_ir_s;
    logic                w_ir_bit;
    logic [1:0]          w_status;

    ir_sync #(
        .WIDTH (NUM_CH)
    ) u_ir_sync (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .i_d   (ir_in),
        .o_q   (w_ir_s)
    );

    // Only the channel that owns the datapath is counted
    assign w_ir_bit = w_ir_s[r_ch_sel];

    // A count equal to the threshold counts as clear
    assign w_status = (r_high_cnt < THRESH) ? IR_DET : IR_CLR;

    // Next-state, counter and output decode for the scan FSM
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_ch_sel_nxt    = r_ch_sel;
        w_slot_nxt      = r_slot_cnt;
        w_high_nxt      = r_high_cnt;
        w_iflags_nxt    = r_iflags;
        w_flags_upd_nxt = 1'b0;
        w_scan_done_nxt = 1'b0;
        w_emit_nxt      = '0;

        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt = SETTLE;
                end
            end

            SETTLE: begin
                w_slot_nxt = r_slot_cnt + 1'b1;
                w_high_nxt = '0;
                if (r_slot_cnt == SETTLE_LAST) begin
                    w_state_nxt = MEASURE;
                end
            end

            MEASURE: begin
                w_slot_nxt = r_slot_cnt + 1'b1;
                if (w_ir_bit && (r_high_cnt != '1)) begin
                    w_high_nxt = r_high_cnt + 1'b1;
                end
                if (r_slot_cnt == WINDOW_LAST) begin
                    // Strobes are registered so they are high during UPDATE
                    w_state_nxt     = UPDATE;
                    w_flags_upd_nxt = 1'b1;
                    w_scan_done_nxt = (r_ch_sel == LAST_CH);
                end
            end

            UPDATE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_ch_sel == CH_W'(i)) begin
                        w_iflags_nxt[2*i +: 2] = w_status;
                    end
                end
                w_slot_nxt   = '0;
                w_high_nxt   = '0;
                w_ch_sel_nxt = (r_ch_sel == LAST_CH) ? '0 : r_ch_sel + 1'b1;
                w_state_nxt  = run ? SETTLE : IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Emitter follows the slot owner whenever the next state is active
        if ((w_state_nxt == SETTLE) || (w_state_nxt == MEASURE)) begin
            w_emit_nxt[w_ch_sel_nxt] = 1'b1;
        end
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state     <= IDLE;
            r_ch_sel    <= '0;
            r_slot_cnt  <= '0;
            r_high_cnt  <= '0;
            r_iflags    <= '0;
            r_emit_en   <= '0;
            r_flags_upd <= 1'b0;
            r_scan_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ch_sel    <= w_ch_sel_nxt;
            r_slot_cnt  <= w_slot_nxt;
            r_high_cnt  <= w_high_nxt;
            r_iflags    <= w_iflags_nxt;
            r_emit_en   <= w_emit_nxt;
            r_flags_upd <= w_flags_upd_nxt;
            r_scan_done <= w_scan_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign emit_en   = r_emit_en;
    assign ch_sel    = r_ch_sel;
    assign iflags    = r_iflags;
    assign flags_upd = r_flags_upd;
    assign scan_done = r_scan_done;
    assign busy      = r_busy;

endmodule
